// File: rtl/i2s_tx_if.sv
// i2s_tx_if: stereo sample handshake between an audio producer and the I2S transmitter
interface i2s_tx_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] sample_l;
  logic [WIDTH-1:0] sample_r;
  logic             sample_valid;
  logic             sample_ready;
  modport master (output sample_l, sample_r, sample_valid, input sample_ready);
  modport slave  (input sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter with a one-deep stereo holding buffer
module i2s_tx #(
  parameter int WIDTH    = 16,
  parameter int BCLK_DIV = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  i2s_tx_if.slave s,
  output logic    underrun,
  output logic    bclk,
  output logic    lrclk,
  output logic    sdata
);
  localparam int FW = 2 * WIDTH;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(FW);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, k;
  logic [FW-1:0] shreg, last_word, hold;
  logic          ready, tick, fe, load, accept;
  always_comb begin
    tick   = div_cnt == DW'(BCLK_DIV - 1);
    fe     = tick & bclk;
    k      = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
    load   = fe & (k == '0);
    accept = s.sample_valid & ready;
  end
  assign s.sample_ready = ready;
  // sdata takes the pre-shift MSB, which yields the one-bclk I2S data delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= BW'(FW - 1);
      shreg     <= '0;
      last_word <= '0;
      hold      <= '0;
      ready     <= 1'b1;
      bclk      <= 1'b0;
      lrclk     <= 1'b1;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
      bclk     <= bclk ^ tick;
      underrun <= load & ready;
      if (fe) begin
        bit_cnt <= k;
        lrclk   <= k >= BW'(WIDTH);
        sdata   <= shreg[FW-1];
        shreg   <= load ? (ready ? last_word : hold) : shreg << 1;
      end
      if (load & ~ready) last_word <= hold;
      if (accept) begin
        hold  <= {s.sample_l, s.sample_r};
        ready <= 1'b0;
      end else if (load) begin
        ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized bench checking i2s_tx against a time-indexed frame model
module tb_i2s_tx;
  localparam int W = 16, D = 8, FW = 2 * W, FP = 2 * D * FW;
  logic clk = 0, rst_n = 0;
  logic underrun, bclk, lrclk, sdata;
  int total = 0, bad = 0, t = 0;
  int m, k;
  logic acc, m_full = 0, e_bclk = 0, e_lr = 1, e_sd = 0, e_ur = 0, e_rdy = 1;
  logic [FW-1:0] m_hold = '0, m_cur = '0, prev;
  logic [31:0] word, lrw;
  logic [W-1:0] base;
  logic rdy;
  i2s_tx_if #(.WIDTH(W)) bus ();
  i2s_tx #(.WIDTH(W), .BCLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave),
    .underrun(underrun), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask
  // Reference: t counts clk edges since reset release; bclk, fe and frame slots follow from t directly
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t = 0; m_full = 0; m_hold = '0; m_cur = '0;
      e_bclk = 0; e_lr = 1; e_sd = 0; e_ur = 0; e_rdy = 1;
    end else begin
      acc = bus.sample_valid && !m_full;
      t++;
      e_bclk = ((t / D) % 2) == 1;
      e_ur = 0;
      if (t % (2 * D) == 0) begin
        m = t / (2 * D);
        k = (m - 1) % FW;
        prev = m_cur;
        if (k == 0) begin
          if (m_full) begin m_cur = m_hold; m_full = 0; end
          else e_ur = 1;
        end
        e_lr = k >= W;
        e_sd = (k == 0) ? prev[0] : m_cur[FW-k];
      end
      if (acc) begin m_hold = {bus.sample_l, bus.sample_r}; m_full = 1; end
      e_rdy = !m_full;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("bclk", bclk, e_bclk);
    chk("lrclk", lrclk, e_lr);
    chk("sdata", sdata, e_sd);
    chk("underrun", underrun, e_ur);
    chk("ready", bus.sample_ready, e_rdy);
  end
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 1);
    chk("rst_sdata", sdata, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", bus.sample_ready, 1);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic run_to(input int tt);
    for (int i = 0; i < tt + 8 && t < tt; i++) @(negedge clk);
  endtask
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    bus.sample_l = l; bus.sample_r = r; bus.sample_valid = 1;
    for (int i = 0; i < 4 * FP && !bus.sample_ready; i++) @(negedge clk);
    chk("send_ready", bus.sample_ready, 1);
    @(negedge clk);
    bus.sample_valid = 0;
  endtask
  initial begin
    bus.sample_valid = 0; bus.sample_l = '0; bus.sample_r = '0;
    // first frame decoded at bclk rises for slots k=1..32
    do_reset();
    send(16'hA5F0, 16'h0F3C);
    word = '0; lrw = '0;
    while (t < 16 * 34) begin
      if (t % 16 == 8 && t / 16 >= 2 && t / 16 <= 33) begin
        word = {word[30:0], sdata};
        lrw = {lrw[30:0], lrclk};
      end
      @(negedge clk);
    end
    chk("frame1_data", word, 32'hA5F00F3C);
    chk("frame1_lr", lrw, 32'h0001FFFE);
    run_to(16 + 3 * FP);
    // never fed
    do_reset();
    run_to(16 + 3 * FP);
    // fed once, then repeats
    do_reset();
    send(16'h8000, 16'h7FFF);
    run_to(16 + 3 * FP + 20);
    // accept on the very clk of an empty-hold frame load
    do_reset();
    run_to(16 + FP - 1);
    bus.sample_l = W'($urandom); bus.sample_r = W'($urandom); bus.sample_valid = 1;
    @(negedge clk);
    bus.sample_valid = 0;
    chk("edge_underrun", underrun, 1);
    chk("edge_ready", bus.sample_ready, 0);
    run_to(16 + 3 * FP);
    // continuous producer with incrementing pairs, then reset mid-frame at k=20
    do_reset();
    base = W'($urandom);
    bus.sample_l = base; bus.sample_r = base + 1'b1; bus.sample_valid = 1;
    for (int i = 0; i < 6 * FP && (t < 16 + 4 * FP || t % FP != 348); i++) begin
      rdy = bus.sample_ready;
      @(negedge clk);
      if (rdy) begin
        base = base + W'(2);
        bus.sample_l = base; bus.sample_r = base + 1'b1;
      end
    end
    chk("pre_rst_bclk", bclk, 1);
    bus.sample_valid = 0;
    do_reset();
    run_to(16 + FP + 20);
    // random producer
    for (int i = 0; i < 2 * FP; i++) begin
      bus.sample_valid = 1'($urandom_range(0, 1));
      bus.sample_l = W'($urandom); bus.sample_r = W'($urandom);
      @(negedge clk);
    end
    bus.sample_valid = 0;
    run_to(t + 2 * FP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Parallel-to-serial I2S (Philips format) transmitter, master mode.
- Generates bclk, lrclk and sdata for an external stereo DAC/codec from a single system clock.
- Accepts stereo samples through a valid/ready handshake into a one-deep holding buffer.
- Transmit-side counterpart to the microphone receive path; fed by audio processing logic in the top level.

Parameters:
- WIDTH, 16, bits per channel sample; frame is 2*WIDTH bclk periods, with no padding.
- BCLK_DIV, 8, clk cycles per bclk half-period; must be ≥2. bclk period = 2*BCLK_DIV clk.

Ports:
- clk  in  1  system clock (25 MHz on board).
- rst_n  in  1  asynchronous active-low reset.
- sample_l  in  WIDTH  left sample, two's complement.
- sample_r  in  WIDTH  right sample, two's complement.
- sample_valid  in  1  sample pair valid.
- sample_ready  out  1  holding buffer empty; a transfer occurs on valid&ready at a clk edge.
- underrun  out  1  one-clk pulse when a frame starts with an empty holding buffer.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.

Behaviour:
- Reset (async, all registers):
  - bclk=0, lrclk=1, sdata=0, underrun=0.
  - div_cnt=0, bit_cnt=2*WIDTH-1, shreg=0, last_word=0, hold empty, so sample_ready=1.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk toggles on the clk edge where div_cnt==BCLK_DIV-1.
  - First toggle after reset is a rising edge.
- Falling-edge event (fe): the clk edge on which bclk goes 1->0. All serial state updates only on fe.
- On fe:
  - bit_cnt advances to k = (bit_cnt+1) mod 2*WIDTH.
  - lrclk <= (k >= WIDTH).
  - sdata <= shreg[2*WIDTH-1], taken from the pre-update shreg.
- If k != 0: shreg <= shreg << 1.
- If k == 0 (frame load):
  - Hold full: shreg <= {hold_l,hold_r}; last_word <= same; hold becomes empty.
  - Hold empty: shreg <= last_word (repeat previous frame); underrun=1 for that clk only.
- Resulting I2S one-bit delay:
  - At k=0 sdata carries the previous frame's right LSB.
  - At k=1 sdata carries the left MSB.
  - At k=WIDTH (lrclk just rose) sdata carries the left LSB.
  - At k=WIDTH+1 sdata carries the right MSB.
- Handshake:
  - sample_ready = hold empty (registered).
  - valid&ready captures sample_l/sample_r into hold; ready drops the next cycle.
  - valid while not ready is ignored; the producer holds its data.
- Simultaneous cases:
  - Frame load with hold empty in the same cycle as valid&ready: the load uses last_word and underrun pulses. The new pair is captured into hold and used at the next frame.
  - Frame load with hold full in the same cycle: ready was 0, so no accept. Hold empties, and ready=1 on the next clk.
- Timing:
  - First fe occurs 2*BCLK_DIV clk cycles after reset release; it is a frame load at k=0.
  - Frame length = 4*WIDTH*BCLK_DIV clk (512 at defaults, 48.83 kHz at 25 MHz).
- Reset mid-frame: all outputs return to reset values immediately. No partial-frame state survives, and hold is discarded.
- lrclk and sdata change only on bclk falling edges; they are stable across every bclk rising edge.

Test Plan:
- Reset, present L=16'hA5F0, R=16'h0F3C before first fe -> first full frame sdata (sampled on bclk rise, k=1..32) = A5F0 then 0F3C MSB-first; lrclk low for k=0..15, high for k=16..31; underrun never pulses.
- No sample supplied after reset -> underrun pulses once per frame (every 512 clk); sdata all zeros; sample_ready stays 1.
- Supply 8000/7FFF once, then nothing -> the same frame repeats each frame; underrun pulses at every frame start after the first.
- Hold valid high continuously with incrementing data -> exactly one accept per frame, no underruns; transmitted pairs are consecutive in order with no duplicates.
- Assert valid&ready on the exact clk of a k=0 load with hold empty -> underrun=1 that clk; the new pair appears in the following frame.
- Assert rst_n low at k=20 -> bclk=0, lrclk=1, sdata=0, sample_ready=1 asynchronously; after release, the first fe occurs 16 clk later as a frame load.
